// File: rtl/miriscv_lsu_pkg.sv
// rtl/miriscv_lsu_pkg.sv - shared LSU types and helpers
package miriscv_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } aligner_state_e;

  function automatic logic [3:0] bytes_of_size(input mem_size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/miriscv_load_extend.sv
// rtl/miriscv_load_extend.sv - sign/zero extension of an NB-byte load value
module miriscv_load_extend
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] bytes_i,
  input  logic [3:0]      nb_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic sign;

  always_comb begin
    sign = 1'b0;
    // sign bit is the top bit of the most significant loaded byte
    for (int k = 0; k < XLEN / 8; k++) begin
      if (int'(nb_i) == k + 1) sign = bytes_i[8*k+7];
    end
    for (int i = 0; i < XLEN; i++) begin
      data_o[i] = (i < 8 * int'(nb_i)) ? bytes_i[i] : (sign & ~unsigned_i);
    end
  end

endmodule

// File: rtl/miriscv_load_aligner.sv
// rtl/miriscv_load_aligner.sv - LSU load-return byte select, beat merge and extension
module miriscv_load_aligner
  import miriscv_lsu_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int DATA_W             = 32,
  parameter int SUPPORT_MISALIGNED = 1,
  localparam int BYTES             = DATA_W / 8,
  localparam int OFF_W             = $clog2(BYTES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OFF_W-1:0]  req_offset_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);

  localparam int XB = XLEN / 8;

  aligner_state_e    state_q;
  logic [OFF_W-1:0]  off_q;
  logic [3:0]        nb_q;
  logic              uns_q;
  logic              cross_q;
  logic [XLEN-1:0]   asm_q;
  logic [XLEN-1:0]   asm_n;
  logic [XLEN-1:0]   ext_data;
  logic [DATA_W-1:0] sh0;
  logic [DATA_W-1:0] sh1;
  int                nb0;

  logic [3:0] req_nb;
  logic       req_cross;
  logic       req_err;

  assign req_nb    = bytes_of_size(mem_size_e'(req_size_i));
  assign req_cross = (int'(req_offset_i) + int'(req_nb)) > BYTES;
  assign req_err   = (req_cross && (SUPPORT_MISALIGNED == 0)) || (int'(req_nb) > XB);

  // beat 0 supplies the bytes up to the word end, beat 1 the remainder stacked above
  always_comb begin
    asm_n = asm_q;
    nb0   = cross_q ? (BYTES - int'(off_q)) : int'(nb_q);
    sh0   = mem_rdata_i >> (8 * int'(off_q));
    sh1   = mem_rdata_i << (8 * nb0);
    for (int i = 0; i < XB; i++) begin
      if (state_q == BEAT0 && i < nb0)
        asm_n[8*i+:8] = sh0[8*i+:8];
      if (state_q == BEAT1 && i >= nb0 && i < int'(nb_q))
        asm_n[8*i+:8] = sh1[8*i+:8];
    end
  end

  miriscv_load_extend #(.XLEN(XLEN)) u_extend (
    .bytes_i    (asm_n),
    .nb_i       (nb_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      off_q       <= '0;
      nb_q        <= '0;
      uns_q       <= 1'b0;
      cross_q     <= 1'b0;
      asm_q       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      asm_q       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            off_q       <= req_offset_i;
            nb_q        <= req_nb;
            uns_q       <= req_unsigned_i;
            cross_q     <= req_cross;
            asm_q       <= '0;
            req_ready_o <= 1'b0;
            if (req_err) begin
              state_q     <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_data_o  <= '0;
            end else begin
              state_q <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (mem_rvalid_i) begin
            asm_q <= asm_n;
            if (cross_q) begin
              state_q <= BEAT1;
            end else begin
              state_q     <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_data_o  <= ext_data;
            end
          end
        end
        BEAT1: begin
          if (mem_rvalid_i) begin
            asm_q       <= asm_n;
            state_q     <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= ext_data;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_load_aligner.sv
// tb/tb_miriscv_load_aligner.sv - directed self-checking bench for miriscv_load_aligner
module tb_miriscv_load_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic [1:0]  req_offset = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_ready = 1'b0;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_data_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  miriscv_load_aligner #(.XLEN(32), .DATA_W(32), .SUPPORT_MISALIGNED(1)) dut_a (
    .clk_i (clk), .rst_i (rst), .flush_i (flush),
    .req_valid_i (req_valid_a), .req_ready_o (req_ready_a),
    .req_offset_i (req_offset), .req_size_i (req_size), .req_unsigned_i (req_unsigned),
    .mem_rvalid_i (mem_rvalid), .mem_rdata_i (mem_rdata),
    .rsp_valid_o (rsp_valid_a), .rsp_ready_i (rsp_ready),
    .rsp_data_o (rsp_data_a), .rsp_err_o (rsp_err_a)
  );

  miriscv_load_aligner #(.XLEN(32), .DATA_W(32), .SUPPORT_MISALIGNED(0)) dut_b (
    .clk_i (clk), .rst_i (rst), .flush_i (flush),
    .req_valid_i (req_valid_b), .req_ready_o (req_ready_b),
    .req_offset_i (req_offset), .req_size_i (req_size), .req_unsigned_i (req_unsigned),
    .mem_rvalid_i (mem_rvalid), .mem_rdata_i (mem_rdata),
    .rsp_valid_o (rsp_valid_b), .rsp_ready_i (rsp_ready),
    .rsp_data_o (rsp_data_b), .rsp_err_o (rsp_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic [1:0] off, input logic [1:0] size, input logic uns);
    req_offset = off; req_size = size; req_unsigned = uns; req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_req_ready", 32'(req_ready_a), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid_a), 32'd0);
    chk("reset_rsp_data", rsp_data_a, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_a), 32'd0);

    // lb offset 3 signed / unsigned, never a cross access
    req_a(2'd3, 2'd0, 1'b0);
    chk("lb_s_wait_valid", 32'(rsp_valid_a), 32'd0);
    beat(32'h80FF_FF12);
    chk("lb_s_valid", 32'(rsp_valid_a), 32'd1);
    chk("lb_s_data", rsp_data_a, 32'hFFFF_FF80);
    ack();
    chk("lb_s_idle", 32'(req_ready_a), 32'd1);
    req_a(2'd3, 2'd0, 1'b1);
    beat(32'h80FF_FF12);
    chk("lb_u_data", rsp_data_a, 32'h0000_0080);
    ack();

    // lh offset 1 signed
    req_a(2'd1, 2'd1, 1'b0);
    beat(32'h12AB_CD34);
    chk("lh_valid", 32'(rsp_valid_a), 32'd1);
    chk("lh_data", rsp_data_a, 32'hFFFF_ABCD);
    chk("lh_err", 32'(rsp_err_a), 32'd0);
    ack();

    // lw offset 2 crossing into a second beat
    req_a(2'd2, 2'd2, 1'b0);
    beat(32'hDDCC_BBAA);
    chk("lw_x_mid_valid", 32'(rsp_valid_a), 32'd0);
    chk("lw_x_mid_ready", 32'(req_ready_a), 32'd0);
    beat(32'h4433_2211);
    chk("lw_x_valid", 32'(rsp_valid_a), 32'd1);
    chk("lw_x_data", rsp_data_a, 32'h2211_DDCC);
    ack();

    // lh offset 3 crossing, sign from second beat
    req_a(2'd3, 2'd1, 1'b0);
    beat(32'h7F00_0000);
    beat(32'h0000_00F0);
    chk("lh_x_data", rsp_data_a, 32'hFFFF_F07F);
    ack();

    // aligned lw, no extension
    req_a(2'd0, 2'd2, 1'b0);
    beat(32'h8765_4321);
    chk("lw_data", rsp_data_a, 32'h8765_4321);
    ack();

    // 8-byte load on XLEN=32 is an error, response right after accept
    req_a(2'd0, 2'd3, 1'b0);
    chk("ld_err_valid", 32'(rsp_valid_a), 32'd1);
    chk("ld_err_flag", 32'(rsp_err_a), 32'd1);
    chk("ld_err_data", rsp_data_a, 32'd0);
    ack();

    // misaligned unsupported: error, beat in RESP not consumed
    req_offset = 2'd1; req_size = 2'd2; req_unsigned = 1'b0; req_valid_b = 1'b1;
    tick();
    req_valid_b = 1'b0;
    chk("nomis_valid", 32'(rsp_valid_b), 32'd1);
    chk("nomis_err", 32'(rsp_err_b), 32'd1);
    chk("nomis_data", rsp_data_b, 32'd0);
    beat(32'h1234_5678);
    chk("nomis_beat_ignored", rsp_data_b, 32'd0);
    chk("nomis_still_valid", 32'(rsp_valid_b), 32'd1);
    ack();
    chk("nomis_idle", 32'(req_ready_b), 32'd1);
    req_offset = 2'd2; req_size = 2'd1; req_unsigned = 1'b1; req_valid_b = 1'b1;
    tick();
    req_valid_b = 1'b0;
    beat(32'hBEEF_0000);
    chk("nomis_lhu_data", rsp_data_b, 32'h0000_BEEF);
    chk("nomis_lhu_err", 32'(rsp_err_b), 32'd0);
    ack();

    // backpressure with a spurious beat while in RESP
    req_a(2'd0, 2'd0, 1'b1);
    beat(32'h0000_00A5);
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = (i == 2); mem_rdata = 32'hFFFF_FFFF;
      tick();
      chk("bp_data", rsp_data_a, 32'h0000_00A5);
      chk("bp_valid", 32'(rsp_valid_a), 32'd1);
      chk("bp_req_ready", 32'(req_ready_a), 32'd0);
    end
    mem_rvalid = 1'b0;
    ack();
    chk("bp_idle_ready", 32'(req_ready_a), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid_a), 32'd0);
    beat(32'hFFFF_FFFF);
    chk("idle_beat_valid", 32'(rsp_valid_a), 32'd0);
    chk("idle_beat_ready", 32'(req_ready_a), 32'd1);

    // flush in BEAT0 with a beat in the same cycle
    req_a(2'd1, 2'd0, 1'b0);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_5500;
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("flush_ready", 32'(req_ready_a), 32'd1);
    chk("flush_valid", 32'(rsp_valid_a), 32'd0);
    chk("flush_data", rsp_data_a, 32'd0);
    beat(32'h0000_5500);
    chk("flush_late_beat", 32'(rsp_valid_a), 32'd0);

    // put a nonzero value in the response register, then reset during BEAT1
    req_a(2'd0, 2'd0, 1'b1);
    beat(32'h0000_003C);
    chk("pre_rst_data", rsp_data_a, 32'h0000_003C);
    ack();
    req_a(2'd2, 2'd2, 1'b0);
    beat(32'hDDCC_BBAA);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready_a), 32'd1);
    chk("rst_valid", 32'(rsp_valid_a), 32'd0);
    chk("rst_data", rsp_data_a, 32'd0);
    tick();
    rst = 1'b0;
    beat(32'h4433_2211);
    chk("rst_late_beat", 32'(rsp_valid_a), 32'd0);
    chk("rst_late_ready", 32'(req_ready_a), 32'd1);

    // recovery load
    req_a(2'd1, 2'd0, 1'b0);
    beat(32'h0000_7F00);
    chk("recover_data", rsp_data_a, 32'h0000_007F);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
